// File: rtl/hazard_forward_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_forward_unit_pkg
//   Shared definitions for the decode-side hazard/forwarding controller and the
//   execute-stage forwarding muxes that consume its select codes.
//
//   Contents:
//     ENT_VALID/ENT_WB/ENT_MEM/ENT_RD : bit offsets of a flattened scoreboard
//                                       entry {rd, mem_read, write_back, valid}
//     FWD_REGFILE                     : select code meaning "take the register
//                                       file value"
//     sel_width()                     : width of a forwarding select for a
//                                       given scoreboard depth
//     entry_width()                   : width of one flattened entry
// ----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    localparam int ENT_VALID   = 0;
    localparam int ENT_WB      = 1;
    localparam int ENT_MEM     = 2;
    localparam int ENT_RD      = 3;

    localparam int FWD_REGFILE = 0;

    // Select must encode 0 (register file) plus stage numbers 1..depth.
    function automatic int sel_width(input int pipe_depth);
        return $clog2(pipe_depth + 1);
    endfunction

    function automatic int entry_width(input int reg_addr_w);
        return ENT_RD + reg_addr_w;
    endfunction

endpackage : hazard_forward_unit_pkg

// File: rtl/hazard_forward_unit_match_lane.sv
// ----------------------------------------------------------------------------
// hazard_match_lane
//   Per-source-operand search of the in-flight write scoreboard. Finds the
//   youngest pending writer of the operand's register and decides whether its
//   result can already be forwarded or whether decode must wait for it.
//
//   Ports:
//     i_src_valid  : this operand is actually read by the decode instruction
//     i_src_addr   : register address of the operand
//     i_entries    : flattened scoreboard, stage k at [(k-1)*ENT_W +: ENT_W]
//     o_sel        : FWD_REGFILE, or stage number k to forward from
//     o_stall_req  : youngest matching producer is not ready yet
// ----------------------------------------------------------------------------
module hazard_match_lane
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int PIPE_DEPTH = 3,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = sel_width(PIPE_DEPTH),
    parameter int ENT_W      = entry_width(REG_ADDR_W)
) (
    input  logic                        i_src_valid,
    input  logic [REG_ADDR_W-1:0]       i_src_addr,
    input  logic [PIPE_DEPTH*ENT_W-1:0] i_entries,
    output logic [SEL_W-1:0]            o_sel,
    output logic                        o_stall_req
);

    logic [ENT_W-1:0] w_ent;
    logic             w_hit;
    int               w_lat;

    // Walk from the oldest stage to the youngest so that a younger match
    // overwrites any older one. A younger unready producer therefore hides an
    // older ready one: the older value is stale for this reader.
    always_comb begin
        o_sel       = SEL_W'(FWD_REGFILE);
        o_stall_req = 1'b0;
        w_ent       = '0;
        w_hit       = 1'b0;
        w_lat       = ALU_LAT;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            w_ent = i_entries[(k-1)*ENT_W +: ENT_W];
            w_hit = i_src_valid
                  & w_ent[ENT_VALID]
                  & w_ent[ENT_WB]
                  & (w_ent[ENT_RD +: REG_ADDR_W] == i_src_addr);
            w_lat = w_ent[ENT_MEM] ? LOAD_LAT : ALU_LAT;
            if (w_hit) begin
                if (k >= w_lat) begin
                    o_sel       = SEL_W'(k);
                    o_stall_req = 1'b0;
                end else begin
                    o_sel       = SEL_W'(FWD_REGFILE);
                    o_stall_req = 1'b1;
                end
            end
        end
    end

endmodule : hazard_match_lane

// File: rtl/hazard_forward_unit.sv
// ----------------------------------------------------------------------------
// hazard_forward_unit
//   Hazard/forwarding controller beside the decode stage. Keeps a shift-register
//   scoreboard of register-writing instructions issued from decode, produces a
//   forwarding select per source operand, stalls decode on load-use hazards and
//   marks the data word of two-word (immediate) instructions as a bubble slot.
//
//   Ports:
//     i_clk, i_reset        : clock, synchronous active-high reset
//     i_issue_valid         : decode holds a valid instruction
//     i_issue_rd            : destination register of the decode instruction
//     i_issue_write_back    : decode instruction writes a register
//     i_issue_mem_read      : result comes from memory (load/pop)
//     i_issue_imm           : next decode word is immediate data
//     i_src_valid/addr      : per-source read enables and packed addresses
//     i_flush               : flush all post-decode stages
//     o_fwd_sel             : packed per-source select (0 = register file,
//                             k = producer k stages ahead)
//     o_stall               : hold PC and fetch/decode buffer
//     o_bubble              : insert NOP into the decode/exm buffer
//     o_imm_slot            : current decode word is immediate data
//
//   All outputs are combinational from state and inputs so the decode/exm
//   buffer can act on them in the same cycle.
// ----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int PIPE_DEPTH = 3,
    parameter int NUM_SRC    = 2,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_issue_valid,
    input  logic [REG_ADDR_W-1:0]                       i_issue_rd,
    input  logic                                        i_issue_write_back,
    input  logic                                        i_issue_mem_read,
    input  logic                                        i_issue_imm,
    input  logic [NUM_SRC-1:0]                          i_src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]               i_src_addr,
    input  logic                                        i_flush,
    output logic [NUM_SRC*sel_width(PIPE_DEPTH)-1:0]    o_fwd_sel,
    output logic                                        o_stall,
    output logic                                        o_bubble,
    output logic                                        o_imm_slot
);

    localparam int SEL_W = sel_width(PIPE_DEPTH);
    localparam int ENT_W = entry_width(REG_ADDR_W);

    // Scoreboard, bit/element k-1 holds stage k (stage 1 = EXM).
    logic [PIPE_DEPTH-1:0]                 r_valid;
    logic [PIPE_DEPTH-1:0]                 r_wb;
    logic [PIPE_DEPTH-1:0]                 r_mem;
    logic [PIPE_DEPTH-1:0][REG_ADDR_W-1:0] r_rd;
    logic                                  r_imm_pending;

    logic                                  w_accept;
    logic [PIPE_DEPTH*ENT_W-1:0]           w_entries;
    logic [NUM_SRC*SEL_W-1:0]              w_lane_sel;
    logic [NUM_SRC-1:0]                    w_stall_req;

    // ---- decode-stage decisions (combinational) ----
    always_comb begin
        w_entries = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            w_entries[k*ENT_W + ENT_VALID]          = r_valid[k];
            w_entries[k*ENT_W + ENT_WB]             = r_wb[k];
            w_entries[k*ENT_W + ENT_MEM]            = r_mem[k];
            w_entries[k*ENT_W + ENT_RD +: REG_ADDR_W] = r_rd[k];
        end
    end

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_lane
        hazard_match_lane #(
            .REG_ADDR_W (REG_ADDR_W),
            .PIPE_DEPTH (PIPE_DEPTH),
            .ALU_LAT    (ALU_LAT),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W),
            .ENT_W      (ENT_W)
        ) u_lane (
            .i_src_valid (i_src_valid[j]),
            .i_src_addr  (i_src_addr[j*REG_ADDR_W +: REG_ADDR_W]),
            .i_entries   (w_entries),
            .o_sel       (w_lane_sel[j*SEL_W +: SEL_W]),
            .o_stall_req (w_stall_req[j])
        );
    end

    // The immediate data word is not an instruction, so its bit pattern must
    // neither select forwarding nor raise a stall. Flush only suppresses the
    // stall: the selects are meaningless for a flushed instruction anyway.
    always_comb begin
        o_imm_slot = r_imm_pending & ~i_reset;
        o_stall    = (|w_stall_req) & ~r_imm_pending & ~i_flush
                   & ~i_reset & i_issue_valid;
        o_bubble   = o_stall | o_imm_slot;
        o_fwd_sel  = (i_reset | r_imm_pending) ? '0 : w_lane_sel;
        w_accept   = i_issue_valid & ~o_stall & ~o_imm_slot & ~i_flush;
    end

    // ---- scoreboard advance (control) ----
    // Only the valid bits and the immediate flag need clearing; stale payload
    // behind a cleared valid bit is never matched.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_valid       <= '0;
            r_imm_pending <= 1'b0;
        end else begin
            r_valid       <= (r_valid << 1) | PIPE_DEPTH'(w_accept);
            r_imm_pending <= w_accept & i_issue_imm;
        end
    end

    // ---- scoreboard advance (payload) ----
    always_ff @(posedge i_clk) begin
        r_wb    <= (r_wb  << 1) | PIPE_DEPTH'(i_issue_write_back);
        r_mem   <= (r_mem << 1) | PIPE_DEPTH'(i_issue_mem_read);
        r_rd[0] <= i_issue_rd;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            r_rd[k] <= r_rd[k-1];
        end
    end

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic [2:0] issue_rd;
    logic       issue_wb;
    logic       issue_mem;
    logic       issue_imm;
    logic [2:0] src_valid;
    logic [8:0] src_addr;
    logic       flush;

    logic [3:0] sel_a;
    logic       stall_a, bubble_a, imm_a;
    logic [8:0] sel_b;
    logic       stall_b, bubble_b, imm_b;

    // Default configuration
    hazard_forward_unit #(
        .REG_ADDR_W(3), .PIPE_DEPTH(3), .NUM_SRC(2), .ALU_LAT(1), .LOAD_LAT(2)
    ) u_dut_a (
        .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid),
        .i_issue_rd(issue_rd), .i_issue_write_back(issue_wb),
        .i_issue_mem_read(issue_mem), .i_issue_imm(issue_imm),
        .i_src_valid(src_valid[1:0]), .i_src_addr(src_addr[5:0]),
        .i_flush(flush), .o_fwd_sel(sel_a), .o_stall(stall_a),
        .o_bubble(bubble_a), .o_imm_slot(imm_a)
    );

    // Swept configuration
    hazard_forward_unit #(
        .REG_ADDR_W(3), .PIPE_DEPTH(5), .NUM_SRC(3), .ALU_LAT(1), .LOAD_LAT(3)
    ) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid),
        .i_issue_rd(issue_rd), .i_issue_write_back(issue_wb),
        .i_issue_mem_read(issue_mem), .i_issue_imm(issue_imm),
        .i_src_valid(src_valid), .i_src_addr(src_addr),
        .i_flush(flush), .o_fwd_sel(sel_b), .o_stall(stall_b),
        .o_bubble(bubble_b), .o_imm_slot(imm_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a list of issued writers with their issue cycle; the
    // distance of a producer is simply (now - issue cycle).
    typedef struct {
        int         inst;
        int         cyc;
        logic [2:0] rd;
        bit         wb;
        bit         mem;
    } prod_t;

    typedef struct packed {
        logic [8:0] sel;
        logic       stall;
        logic       bubble;
        logic       imm;
    } exp_t;

    prod_t prods[$];
    bit    imm_pend[2];
    int    cycle;
    exp_t  expq_a[$];
    exp_t  expq_b[$];

    int checks;
    int failures;

    function automatic exp_t model(input int inst, input int depth, input int alulat,
                                   input int loadlat, input int ns, input int sw,
                                   output bit acc);
        exp_t e;
        bit   anyreq;
        int   best;
        bit   bmem;
        int   age;
        e      = '0;
        acc    = 1'b0;
        anyreq = 1'b0;
        if (reset) return e;
        e.imm = imm_pend[inst];
        for (int j = 0; j < ns; j++) begin
            if (!e.imm && src_valid[j]) begin
                best = -1;
                bmem = 1'b0;
                foreach (prods[i]) begin
                    age = cycle - prods[i].cyc;
                    if (prods[i].inst == inst && prods[i].wb &&
                        prods[i].rd == src_addr[j*3 +: 3] &&
                        age >= 1 && age <= depth && (best < 0 || age < best)) begin
                        best = age;
                        bmem = prods[i].mem;
                    end
                end
                if (best > 0) begin
                    if (best >= (bmem ? loadlat : alulat))
                        e.sel = e.sel | (9'(best) << (j * sw));
                    else
                        anyreq = 1'b1;
                end
            end
        end
        e.stall  = anyreq && !e.imm && !flush && issue_valid;
        e.bubble = e.stall || e.imm;
        acc      = issue_valid && !e.stall && !e.imm && !flush;
        return e;
    endfunction

    task automatic step(input bit v, input logic [2:0] rd, input bit wb, input bit mem,
                        input bit imm, input logic [2:0] sv, input logic [8:0] sa,
                        input bit fl, input bit rs);
        exp_t  ea, eb;
        bit    acc_a, acc_b;
        prod_t p;
        @(posedge clk);
        #1;
        issue_valid = v;  issue_rd = rd;  issue_wb = wb;  issue_mem = mem;
        issue_imm = imm;  src_valid = sv; src_addr = sa;  flush = fl; reset = rs;
        ea = model(0, 3, 1, 2, 2, 2, acc_a);
        eb = model(1, 5, 1, 3, 3, 3, acc_b);
        expq_a.push_back(ea);
        expq_b.push_back(eb);
        if (rs || fl) begin
            prods.delete();
            imm_pend[0] = 1'b0;
            imm_pend[1] = 1'b0;
        end else begin
            p.cyc = cycle; p.rd = rd; p.wb = wb; p.mem = mem;
            if (acc_a) begin p.inst = 0; prods.push_back(p); end
            if (acc_b) begin p.inst = 1; prods.push_back(p); end
            imm_pend[0] = acc_a && imm;
            imm_pend[1] = acc_b && imm;
        end
        for (int i = prods.size() - 1; i >= 0; i--)
            if (cycle + 1 - prods[i].cyc > 6) prods.delete(i);
        cycle++;
    endtask

    function automatic logic [8:0] addr(input logic [2:0] a0, input logic [2:0] a1,
                                        input logic [2:0] a2);
        return {a2, a1, a0};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    // Monitor: outputs are combinational and presented every cycle; sample
    // mid-cycle, after the driver has settled the inputs.
    always @(negedge clk) begin
        exp_t e;
        if (expq_a.size() > 0) begin
            e = expq_a.pop_front();
            check("a_fwd_sel", int'(sel_a), int'(e.sel[3:0]));
            check("a_stall",   int'(stall_a), int'(e.stall));
            check("a_bubble",  int'(bubble_a), int'(e.bubble));
            check("a_imm_slot", int'(imm_a), int'(e.imm));
        end
        if (expq_b.size() > 0) begin
            e = expq_b.pop_front();
            check("b_fwd_sel", int'(sel_b), int'(e.sel));
            check("b_stall",   int'(stall_b), int'(e.stall));
            check("b_bubble",  int'(bubble_b), int'(e.bubble));
            check("b_imm_slot", int'(imm_b), int'(e.imm));
        end
    end

    task automatic nop();
        step(0, 0, 0, 0, 0, 3'b000, 9'd0, 0, 0);
    endtask

    initial begin
        checks = 0; failures = 0; cycle = 0;
        imm_pend[0] = 1'b0; imm_pend[1] = 1'b0;
        issue_valid = 0; issue_rd = 0; issue_wb = 0; issue_mem = 0; issue_imm = 0;
        src_valid = 0; src_addr = 0; flush = 0; reset = 1;

        // Reset, with a reader active to show outputs forced low
        step(1, 1, 1, 0, 0, 3'b011, addr(1, 1, 0), 0, 1);
        step(0, 0, 0, 0, 0, 3'b000, 9'd0, 0, 1);
        nop();

        // ADD R1; SUB R2,R1; reader of R1 with producer two back
        step(1, 1, 1, 0, 0, 3'b000, 9'd0, 0, 0);
        step(1, 2, 1, 0, 0, 3'b001, addr(1, 0, 0), 0, 0);
        step(1, 3, 1, 0, 0, 3'b010, addr(0, 1, 0), 0, 0);
        nop(); nop(); nop(); nop(); nop();

        // LDD R3 then ADD R4,R3 held in decode while stalled
        step(1, 3, 1, 1, 0, 3'b000, 9'd0, 0, 0);
        repeat (3) step(1, 4, 1, 0, 0, 3'b001, addr(3, 0, 0), 0, 0);
        nop(); nop(); nop(); nop(); nop();

        // Youngest wins: ADD R1, ADD R1, OR R5,R1
        step(1, 1, 1, 0, 0, 3'b000, 9'd0, 0, 0);
        step(1, 1, 1, 0, 0, 3'b000, 9'd0, 0, 0);
        step(1, 5, 1, 0, 0, 3'b001, addr(1, 0, 0), 0, 0);
        nop(); nop(); nop(); nop(); nop();

        // ALU R1 older, LDD R1 younger: reader stalls
        step(1, 1, 1, 0, 0, 3'b000, 9'd0, 0, 0);
        step(1, 1, 1, 1, 0, 3'b000, 9'd0, 0, 0);
        repeat (3) step(1, 2, 1, 0, 0, 3'b011, addr(1, 1, 1), 0, 0);
        nop(); nop(); nop(); nop(); nop();

        // LDM R6,#imm: data word looks like a reader of R6
        step(1, 6, 1, 0, 1, 3'b000, 9'd0, 0, 0);
        step(1, 6, 1, 1, 1, 3'b111, addr(6, 6, 6), 0, 0);
        step(1, 7, 1, 0, 0, 3'b001, addr(6, 0, 0), 0, 0);
        nop(); nop(); nop(); nop(); nop();

        // Load-use stall aborted by flush, then readers see the register file
        step(1, 2, 1, 1, 0, 3'b000, 9'd0, 0, 0);
        step(1, 3, 1, 0, 0, 3'b001, addr(2, 0, 0), 1, 0);
        step(1, 4, 1, 0, 0, 3'b111, addr(2, 2, 2), 0, 0);
        nop(); nop(); nop(); nop(); nop();

        // Retirement past the deepest stage, then reset mid-stall
        step(1, 5, 1, 0, 0, 3'b000, 9'd0, 0, 0);
        repeat (6) step(1, 0, 0, 0, 0, 3'b111, addr(5, 5, 5), 0, 0);
        step(1, 4, 1, 1, 0, 3'b000, 9'd0, 0, 0);
        step(1, 1, 1, 0, 0, 3'b001, addr(4, 0, 0), 0, 0);
        step(1, 1, 1, 0, 0, 3'b001, addr(4, 0, 0), 0, 1);
        step(1, 1, 1, 0, 0, 3'b001, addr(4, 0, 0), 0, 0);
        nop(); nop();

        // Randomized traffic over a small register set to force hazards
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 8,
                 3'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 1,
                 3'($urandom_range(0, 7)),
                 addr(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                      3'($urandom_range(0, 3))),
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 2);
        end

        @(posedge clk);
        @(posedge clk);
        check("queues_drained", expq_a.size() + expq_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_forward_unit

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard/forwarding controller sitting beside the decode stage. It tracks every in-flight register-writing instruction issued from decode, in a shift-register scoreboard PIPE_DEPTH entries deep.
For each source operand of the instruction in decode, it produces a forwarding select, and raises a stall plus bubble on a load-use hazard.
It also marks the second word of two-word immediate instructions (LDM) as a non-instruction slot, replacing the ad-hoc buffer-reset approach with explicit bubble control.

Parameters:
REG_ADDR_W, 3, register address width
PIPE_DEPTH, 3, number of post-decode stages that can hold a pending write (stage 1 = EXM)
NUM_SRC, 2, source operands checked per instruction
ALU_LAT, 1, minimum distance k at which a non-load result is forwardable
LOAD_LAT, 2, minimum distance k at which a load result is forwardable (LOAD_LAT >= ALU_LAT)
SEL_W, clog2(PIPE_DEPTH+1), forwarding select width (derived localparam)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_issue_valid  in  1  decode holds a valid instruction
i_issue_rd  in  REG_ADDR_W  destination register of decode instruction
i_issue_write_back  in  1  decode instruction writes a register
i_issue_mem_read  in  1  decode instruction is a load/pop (result from memory)
i_issue_imm  in  1  decode instruction is two-word; next decode word is immediate data
i_src_valid  in  NUM_SRC  per-source "operand is read"
i_src_addr  in  NUM_SRC*REG_ADDR_W  packed source addresses, source j at [j*REG_ADDR_W +: REG_ADDR_W]
i_flush  in  1  branch/interrupt flush of all post-decode stages
o_fwd_sel  out  NUM_SRC*SEL_W  packed per-source select: 0 = register file, k = forward from producer k stages ahead
o_stall  out  1  hold PC and fetch/decode buffer this cycle
o_bubble  out  1  insert NOP into decode/exm buffer this cycle
o_imm_slot  out  1  current decode word is immediate data, not an instruction

Behaviour:
- Scoreboard: entries e[1..PIPE_DEPTH], each {valid, rd, write_back, mem_read}.
- Every clock: e[k+1] <= e[k]; e[PIPE_DEPTH] is discarded.
- e[1] <= the decode entry if accepted, otherwise a bubble (valid=0). Accepted = i_issue_valid & !o_stall & !o_imm_slot & !i_flush.
- Match for source j at stage k: i_src_valid[j] & e[k].valid & e[k].write_back & e[k].rd == src_addr j.
- Priority: the smallest k (youngest producer) wins. No match gives sel 0. Producers retired past PIPE_DEPTH are visible in the register file (regfile write-before-read is required).
- Readiness: the winning entry is ready iff k >= (e[k].mem_read ? LOAD_LAT : ALU_LAT).
  - Ready: o_fwd_sel[j] = k.
  - Not ready: o_fwd_sel[j] = 0 and that source requests a stall.
  - An older matching entry never overrides a younger unready one.
- o_stall = OR of per-source stall requests, gated by !o_imm_slot & !i_flush & !i_reset & i_issue_valid. o_bubble = o_stall | o_imm_slot.
- Stall duration is exactly LOAD_LAT - k cycles, because bubbles advance the producer each cycle.
- Outputs are combinational from state and inputs (same-cycle use by the decode/exm buffer).
- Immediate slot: a 1-bit register, imm_pending <= accepted & i_issue_imm. o_imm_slot = imm_pending.
  - While o_imm_slot=1: all o_fwd_sel = 0, o_stall = 0, e[1] gets a bubble.
  - It lasts exactly one cycle and cannot chain.
- Flush (synchronous): on the next edge all entries are cleared to invalid and imm_pending is cleared. During the flush cycle o_stall = 0, and the decode instruction is not recorded. Flush has priority over issue and stall.
- Reset: on the edge with i_reset=1, all entries are invalid and imm_pending=0. While i_reset=1, o_fwd_sel=0, o_stall=0, o_bubble=0, o_imm_slot=0.
- Reset or flush during a stall aborts the stall immediately with no residual bubble.
- Widths: rd compare is full REG_ADDR_W equality. There is no hard-wired zero register; all 2^REG_ADDR_W registers are trackable.

Decomposition:
- Shared include/package holds:
  - SEL_W computation
  - scoreboard entry field offsets (VALID, WB, MEM, RD)
  - the FWD_REGFILE=0 constant, reused by the exm stage forwarding muxes
- One sub-module, hazard_match_lane: per-source priority search plus readiness check. It is instantiated NUM_SRC times via generate, and outputs {sel, stall_req}.

Test Plan:
- ADD R1 issued, then SUB R2,R1 next cycle (defaults) -> o_fwd_sel[src0]=1, o_stall=0; with producer two cycles back -> sel=2.
- LDD R3 then ADD R4,R3 back-to-back -> o_stall=1, o_bubble=1 for exactly 1 cycle, then sel=2 on the following cycle, PC held one cycle.
- ADD R1, ADD R1, then OR R5,R1 -> sel=1 (youngest wins, not 2). LDD R1 at k=1 with older ALU R1 at k=2 -> stall, not sel=2.
- LDM R6,#0x0005 (i_issue_imm=1): next cycle o_imm_slot=1, o_bubble=1, o_fwd_sel=0, even if the data word's bit field matches R6 -> no stall. A following reader of R6 gets sel=2.
- Stall pending on load-use and i_flush=1 same cycle -> o_stall=0; next cycle all sel=0 for any source address.
- Parameter sweep PIPE_DEPTH=5, LOAD_LAT=3, NUM_SRC=3: load then immediate reader -> 2 stall cycles, then sel=3. Entry retired past k=5 -> sel=0. i_reset mid-stall -> all outputs 0 that cycle.
